// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory request/response bus between fetch unit and imem.
interface if_fetch_unit_if #(parameter int NBits = 32) ();

  logic             imem_req_o;
  logic [NBits-1:0] imem_addr_o;
  logic             imem_ack_i;
  logic [NBits-1:0] imem_rdata_i;

  modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_rdata_i);
  modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_rdata_i);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an instruction that returned while IF/ID was stalled.
module fetch_skid_buf #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             park_i,
  input  logic             pop_i,
  input  logic [NBits-1:0] park_instr_i,
  input  logic [NBits-1:0] park_pc_i,
  output logic             full_o,
  output logic [NBits-1:0] instr_o,
  output logic [NBits-1:0] pc_o
);

  logic             full_q, full_d;
  logic [NBits-1:0] instr_q, instr_d;
  logic [NBits-1:0] pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (park_i) begin
      full_d  = 1'b1;
      instr_d = park_instr_i;
      pc_d    = park_pc_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: one outstanding imem fetch, registered IF/ID outputs, redirect/stall handling.
// Define FETCH_SKID_EN to keep an instruction returning under stall instead of re-fetching it.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = NBits'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [NBits-1:0]  redirect_pc_i,
  if_fetch_unit_if.master   imem,
  output logic [NBits-1:0]  pc_o,
  output logic [NBits-1:0]  pc_plus_4_o,
  output logic [NBits-1:0]  instruction_o,
  output logic              valid_o
);

  localparam logic [NBits-1:0] NOP  = NBits'(NOP_INSTR);
  localparam logic [NBits-1:0] FOUR = NBits'(4);

  fetch_state_e     state_q, state_d;
  logic [NBits-1:0] pc_q, pc_d;
  logic [NBits-1:0] pc_out_q, pc_out_d;
  logic [NBits-1:0] pc4_out_q, pc4_out_d;
  logic [NBits-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             stale_q, stale_d;
  logic             ack_v, req, skid_full, skid_park, skid_pop, skid_clear;
  logic [NBits-1:0] addr, skid_instr, skid_pc;

`ifdef FETCH_SKID_EN
  localparam bit SkidEn = 1'b1;
  fetch_skid_buf #(.NBits(NBits)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (skid_clear),
    .park_i       (skid_park),
    .pop_i        (skid_pop),
    .park_instr_i (imem.imem_rdata_i),
    .park_pc_i    (pc_q),
    .full_o       (skid_full),
    .instr_o      (skid_instr),
    .pc_o         (skid_pc)
  );
`else
  localparam bit SkidEn = 1'b0;
  logic skid_unused;
  assign skid_full   = 1'b0;
  assign skid_instr  = '0;
  assign skid_pc     = '0;
  assign skid_unused = ^{skid_clear, skid_park, skid_pop};
`endif

  // A response still owed for a request abandoned by reset must not be taken as ours.
  assign ack_v = imem.imem_ack_i & ~stale_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stale_d    = stale_q & ~imem.imem_ack_i;
    pc_out_d   = pc_out_q;
    pc4_out_d  = pc4_out_q;
    instr_d    = NOP;
    valid_d    = 1'b0;
    req        = 1'b0;
    addr       = pc_q;
    skid_park  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
    if (reset) begin
      stale_d = (stale_q | (state_q != ST_IDLE)) & ~imem.imem_ack_i;
    end else if (redirect_i) begin
      pc_d       = {redirect_pc_i[NBits-1:2], 2'b00};
      skid_clear = 1'b1;
      state_d    = (state_q != ST_IDLE && !ack_v) ? ST_DRAIN : ST_IDLE;
    end else if (stall_i) begin
      instr_d = instr_q;
      valid_d = valid_q;
      if (ack_v && state_q == ST_WAIT) begin
        state_d = ST_IDLE;
        if (SkidEn) begin
          skid_park = 1'b1;
          pc_d      = pc_q + FOUR;
        end
      end else if (ack_v && state_q == ST_DRAIN) begin
        state_d = ST_IDLE;
      end
    end else begin
      // Skid is only ever full in IDLE, so it never collides with an imem delivery.
      if (skid_full) begin
        skid_pop  = 1'b1;
        instr_d   = skid_instr;
        pc_out_d  = skid_pc;
        pc4_out_d = skid_pc + FOUR;
        valid_d   = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          req     = 1'b1;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (ack_v) begin
            instr_d   = imem.imem_rdata_i;
            pc_out_d  = pc_q;
            pc4_out_d = pc_q + FOUR;
            valid_d   = 1'b1;
            pc_d      = pc_q + FOUR;
            req       = 1'b1;
            addr      = pc_q + FOUR;
          end
        end
        ST_DRAIN: begin
          if (ack_v) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // stale_q deliberately survives reset: it records what reset itself abandoned.
  always_ff @(posedge clk) begin
    stale_q <= stale_d;
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pc_out_q  <= '0;
      pc4_out_q <= '0;
      instr_q   <= NOP;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      pc4_out_q <= pc4_out_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = addr;
  assign pc_o             = pc_out_q;
  assign pc_plus_4_o      = pc4_out_q;
  assign instruction_o    = instr_q;
  assign valid_o          = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order variable-latency imem model plus a delivered-stream scoreboard.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, stall_i, redirect_i;
  logic [31:0] redirect_pc_i, pc_o, pc_plus_4_o, instruction_o;
  logic        valid_o;

  if_fetch_unit_if #(.NBits(32)) imem ();

  if_fetch_unit #(.NBits(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem),
    .pc_o          (pc_o),
    .pc_plus_4_o   (pc_plus_4_o),
    .instruction_o (instruction_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc_n  = 0;
  int    lat_lo = 1;
  int    lat_hi = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return ((a * 32'h9E37_79B1) ^ 32'h5A00_0000) | 32'h1;
  endfunction

  logic [31:0] exp_pc, redir_tgt, addr_seen;
  logic [31:0] prev_pc, prev_p4, prev_ins;
  logic        prev_v, req_seen;
  bit          redir_pend;
  int          n_deliv = 0;

  // One clock: drive inputs + memory ack, check the request, then check registered outputs.
  task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rp);
    reset = r; stall_i = st; redirect_i = rd; redirect_pc_i = rp;
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      imem.imem_ack_i   = 1'b1;
      imem.imem_rdata_i = memf(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem.imem_ack_i   = 1'b0;
      imem.imem_rdata_i = $urandom;
    end
    #1;
    req_seen  = imem.imem_req_o;
    addr_seen = imem.imem_addr_o;
    if (r || rd || st) chk("no_req", req_seen, 32'h0);
    else if (req_seen && redir_pend) begin
      chk("first_req_addr", addr_seen, redir_tgt);
      redir_pend = 0;
    end
    if (req_seen && !r) begin
      int due;
      due = cyc_n + int'($urandom_range(lat_hi, lat_lo));
      if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
      mq.push_back('{addr_seen, due});
    end
    prev_pc = pc_o; prev_p4 = pc_plus_4_o; prev_ins = instruction_o; prev_v = valid_o;
    @(posedge clk);
    #1;
    cyc_n++;
    if (r) begin
      chk("rst_valid", valid_o, 32'h0);
      chk("rst_instr", instruction_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_pc4", pc_plus_4_o, 32'h0);
      exp_pc = RST_PC; redir_tgt = RST_PC; redir_pend = 1;
    end else if (rd) begin
      chk("redir_valid", valid_o, 32'h0);
      chk("redir_instr", instruction_o, NOP_INSTR);
      exp_pc = rp & ~32'h3; redir_tgt = exp_pc; redir_pend = 1;
    end else if (st) begin
      chk("hold_valid", valid_o, prev_v);
      chk("hold_pc", pc_o, prev_pc);
      chk("hold_pc4", pc_plus_4_o, prev_p4);
      chk("hold_instr", instruction_o, prev_ins);
    end else if (valid_o) begin
      chk("deliv_pc", pc_o, exp_pc);
      chk("deliv_pc4", pc_plus_4_o, exp_pc + 32'd4);
      chk("deliv_instr", instruction_o, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end else begin
      chk("bubble_nop", instruction_o, NOP_INSTR);
    end
    @(negedge clk);
  endtask

  initial begin
    int run, best, seen, n0;
    bit found;
    logic [31:0] a_last, rp;
    imem.imem_ack_i = 1'b0; imem.imem_rdata_i = '0;
    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    exp_pc = RST_PC; redir_tgt = RST_PC; redir_pend = 1;

    // reset, then boot streaming from a 1-cycle memory
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("boot_req", req_seen, 32'h1);
    chk("boot_addr", addr_seen, RST_PC);
    run = 0; best = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      if (i == 0) begin
        chk("boot_first_instr", instruction_o, 32'h2008_0005);
        chk("boot_first_pc4", pc_plus_4_o, 32'h0040_0004);
      end
      run  = valid_o ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    chk("stream_run4", (best >= 4), 32'h1);

    // redirect while a 3-cycle fetch is outstanding
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(0, 0, 0, 0); found = req_seen; end
    chk("redir_setup", found, 32'h1);
    cyc(0, 0, 1, 32'h0040_0043);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (req_seen) begin found = 1; chk("redir_next_addr", addr_seen, 32'h0040_0040); end
    end
    chk("redir_req_seen", found, 32'h1);

    // stall for 3 cycles with the ack landing in the first stall cycle
    lat_lo = 1; lat_hi = 1;
    repeat (6) cyc(0, 0, 0, 0);
    chk("pre_stall_req", req_seen, 32'h1);
    a_last = addr_seen;
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("post_stall_req", req_seen, 32'h1);
`ifdef FETCH_SKID_EN
    chk("post_stall_addr", addr_seen, a_last + 32'd4);
    chk("post_stall_valid", valid_o, 32'h1);
`else
    chk("post_stall_addr", addr_seen, a_last);
    chk("post_stall_valid", valid_o, 32'h0);
`endif

    // PC wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    seen = 0; found = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (req_seen) begin
        if (seen == 1) chk("wrap_next_addr", addr_seen, 32'h0);
        seen++;
      end
      if (valid_o && pc_o == 32'hFFFF_FFFC && !found) begin
        found = 1;
        chk("wrap_pc4", pc_plus_4_o, 32'h0);
      end
    end
    chk("wrap_found", found, 32'h1);

    // reset while a fetch is outstanding; its late ack must be ignored
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(0, 0, 0, 0); found = req_seen; end
    chk("rstw_setup", found, 32'h1);
    cyc(1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (valid_o) begin
        found = 1;
        chk("rstw_first_pc", pc_o, RST_PC);
        chk("rstw_first_instr", instruction_o, 32'h2008_0005);
      end
    end
    chk("rstw_deliv_seen", found, 32'h1);

    // random stall/redirect/latency mix
    lat_lo = 1; lat_hi = 3;
    n0 = n_deliv;
    for (int i = 0; i < 1500; i++) begin
      rp = (32'h0040_0000 + 32'($urandom_range(1023)) * 32'd4) | 32'($urandom_range(3));
      cyc(0, ($urandom_range(3) == 0), ($urandom_range(15) == 0), rp);
    end
    chk("rand_liveness", ((n_deliv - n0) > 150), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter NBits, default 32, SHALL set PC and instruction width.
REQ-002 Parameter RESET_PC, default 32'h00400000, SHALL set the PC value loaded at reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 stall_i  input  1  SHALL mean the hazard unit holds the IF/ID stage this cycle.
REQ-006 redirect_i  input  1  SHALL mean a taken branch or jump this cycle.
REQ-007 redirect_pc_i  input  NBits  SHALL be the target PC; bits [1:0] are ignored and forced to 0.
REQ-008 imem_req_o  output  1  SHALL be a single-cycle fetch request pulse.
REQ-009 imem_addr_o  output  NBits  SHALL be the fetch address, valid when imem_req_o=1.
REQ-010 imem_ack_i  input  1  SHALL be a single-cycle response pulse, 1..N cycles after the request.
REQ-011 imem_rdata_i  input  NBits  SHALL be the instruction word, valid when imem_ack_i=1.
REQ-012 pc_o, pc_plus_4_o, instruction_o  output  NBits each  SHALL be registered IF/ID inputs: PC, PC+4, instruction.
REQ-013 valid_o  output  1  SHALL be 1 when the IF/ID outputs hold a real instruction, 0 for a bubble.

Function
REQ-014 The FSM SHALL have states IDLE (no request outstanding), WAIT (one request outstanding) and DRAIN (discard one stale response).
REQ-015 Event priority SHALL be reset > redirect_i > stall_i > imem_ack_i.
REQ-016 In IDLE with stall_i=0 and redirect_i=0, the block SHALL pulse imem_req_o with imem_addr_o=pc_q and go to WAIT.
REQ-017 In WAIT, an ack with stall_i=0 and redirect_i=0 SHALL, next cycle, set instruction_o=rdata, pc_o=pc_q, pc_plus_4_o=pc_q+4 and valid_o=1, and SHALL set pc_q=pc_q+4.
REQ-018 In that same ack cycle, the block SHALL issue the next request for pc_q+4 and remain in WAIT, giving 1 instruction/cycle with 1-cycle memory.
REQ-019 Latency SHALL be: request at cycle t, ack at t+k, outputs valid at t+k+1.
REQ-020 PC+4 SHALL wrap modulo 2^NBits: 32'hFFFFFFFC+4 = 0.
REQ-021 When stall_i=1 and redirect_i=0, pc_o, pc_plus_4_o, instruction_o and valid_o SHALL hold, and no new request SHALL be issued.
REQ-022 In any cycle with no delivery and no stall, the block SHALL set valid_o=0 and instruction_o=0 (NOP) next cycle.
REQ-023 On redirect_i=1, the block SHALL, next cycle, set pc_q=redirect_pc_i with [1:0]=0, set valid_o=0 and instruction_o=0, and issue no request that cycle.
REQ-024 For redirect_i=1 in WAIT without ack, the block SHALL go to DRAIN; a same-cycle ack SHALL be discarded and the block SHALL go to IDLE.
REQ-025 In DRAIN, the next ack SHALL be discarded and the block SHALL go to IDLE; a further redirect in DRAIN SHALL update pc_q only.
REQ-026 An ack arriving while stall_i=1 SHALL be handled per REQ-031/032.

Reset
REQ-027 Reset SHALL force state=IDLE, pc_q=RESET_PC, pc_o=0, pc_plus_4_o=0, instruction_o=0, valid_o=0 and imem_req_o=0.
REQ-028 Reset asserted mid-request SHALL abandon the request; the first ack after reset release SHALL be ignored if a request was outstanding at reset.

Configuration
REQ-029 Macro FETCH_SKID_EN SHALL enable a one-entry skid buffer.
REQ-030 The skid buffer SHALL be bypassed on redirect and cleared on redirect or reset.
REQ-031 With FETCH_SKID_EN: an ack under stall SHALL be parked in the skid buffer and pc_q advanced; when stall_i drops, the parked entry SHALL be delivered first, with no re-fetch.
REQ-032 Without FETCH_SKID_EN: an ack under stall SHALL be dropped, pc_q SHALL be unchanged, the FSM SHALL go to IDLE, and the same PC SHALL be re-fetched after stall_i drops.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state enum, the NOP constant (32'h00000000) and the default RESET_PC.
REQ-034 The skid buffer SHALL be sub-module fetch_skid_buf, instantiated only under FETCH_SKID_EN.

Verification
REQ-035 Reset release, 1-cycle memory returning 0x20080005: req addr 0x00400000; next cycle valid_o=1, pc_o=0x00400000, pc_plus_4_o=0x00400004.
REQ-036 Streaming 4 acks, 1-cycle memory: valid_o=1 for 4 consecutive cycles, with pc_o = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-037 redirect_i=1 to 0x00400043 while WAIT with 3-cycle memory: stale ack discarded, valid_o=0, next req addr 0x00400040.
REQ-038 stall_i=1 for 3 cycles with ack in first stall cycle: outputs frozen; skid build delivers it with 0 re-fetches, non-skid build re-issues the same address.
REQ-039 pc_q=0xFFFFFFFC fetch: pc_plus_4_o=0x00000000 and next req addr 0x00000000.
REQ-040 Reset asserted in WAIT, ack arrives 1 cycle after release: ack ignored, first delivered pc_o=0x00400000.
